fetch_ctrl: RTL and testbench

Fetch-side controller that drives the instruction-fetch PC and sequences single-outstanding requests to instruction memory. It arbitrates between the commit-stage exception flush, the execute-stage branch redirect and the predictor's taken hint. Each returned instruction is delivered to decode over a valid/ready handshake, with the PC and the branch-prediction tag carried alongside. It sits between the predictor/pipeline control and the IF/ID boundary.

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_redirect_mux.sv | 26 ++
 rtl/fetch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// Optional branch-prediction support in fetch_ctrl is enabled by defining FETCH_PRED_EN.
package fetch_ctrl_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_INST_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Per-beat metadata travelling with the instruction handed to decode.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic                    branch;
        logic [FETCH_ADDR_W-1:0] branch_addr;
    } fetch_meta_t;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Redirect arbitration: commit-stage exception beats execute-stage branch,
// and the chosen target is forced to word alignment.
module fetch_redirect_mux #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_excp_flush,
    input  logic [ADDR_WIDTH-1:0] i_excp_pc,
    input  logic                  i_br_redirect,
    input  logic [ADDR_WIDTH-1:0] i_br_pc,
    output logic                  o_redirect_c,
    output logic [ADDR_WIDTH-1:0] o_target_c
);

    logic [ADDR_WIDTH-1:0] w_sel;

    always_comb begin
        w_sel = i_br_pc;
        if (i_excp_flush) begin
            w_sel = i_excp_pc;
        end
    end

    assign o_redirect_c = i_excp_flush | i_br_redirect;
    assign o_target_c   = w_sel & ~ADDR_WIDTH'(3);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: one outstanding imem request, redirect handling and IF/ID handshake.
// Define FETCH_PRED_EN to honour pred_taken/pred_pc; otherwise fetch is strictly sequential.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = FETCH_ADDR_W,
    parameter int unsigned           INST_WIDTH = FETCH_INST_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  excp_flush,
    input  logic [ADDR_WIDTH-1:0] excp_pc,
    input  logic                  br_redirect,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  out_branch,
    output logic [ADDR_WIDTH-1:0] out_branch_addr
);

    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_pred_taken;
    logic [ADDR_WIDTH-1:0] w_pred_pc;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_out_pc;
    logic [ADDR_WIDTH-1:0] w_hold_npc;

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic                  r_pend;
    logic                  r_kill;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;
    logic [INST_WIDTH-1:0] r_inst;
    fetch_meta_t           r_meta;

    fetch_redirect_mux #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_redirect_mux (
        .i_excp_flush  (excp_flush),
        .i_excp_pc     (excp_pc),
        .i_br_redirect (br_redirect),
        .i_br_pc       (br_pc),
        .o_redirect_c  (w_redirect),
        .o_target_c    (w_target)
    );

`ifdef FETCH_PRED_EN
    assign w_pred_taken = pred_taken;
    assign w_pred_pc    = pred_pc;
`else
    logic w_unused_pred;
    assign w_pred_taken  = 1'b0;
    assign w_pred_pc     = '0;
    assign w_unused_pred = ^{pred_taken, pred_pc};
`endif

    assign w_out_pc = ADDR_WIDTH'(r_meta.pc);
    assign w_xfer   = (r_state == HOLD) && r_valid && out_ready;

    // Successor PC when leaving HOLD; a redirect always wins over the predictor.
    always_comb begin
        w_hold_npc = w_out_pc + ADDR_WIDTH'(4);
        if (w_redirect) begin
            w_hold_npc = w_target;
        end else if (w_pred_taken) begin
            w_hold_npc = w_pred_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
            r_pend     <= 1'b0;
            r_kill     <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_valid    <= 1'b0;
            r_inst     <= '0;
            r_meta     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                        r_addr     <= w_target;
                    end else begin
                        r_addr <= r_fetch_pc;
                    end
                end
                // Address is frozen until granted; a redirect here kills the in-flight reply.
                REQ: begin
                    if (imem_gnt) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                        r_pend  <= 1'b0;
                        if (w_redirect) begin
                            r_kill     <= 1'b1;
                            r_fetch_pc <= w_target;
                        end else if (r_pend) begin
                            r_kill     <= 1'b1;
                            r_fetch_pc <= r_pend_pc;
                        end
                    end else if (w_redirect) begin
                        r_pend    <= 1'b1;
                        r_pend_pc <= w_target;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill || w_redirect) begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            r_kill  <= 1'b0;
                            if (w_redirect) begin
                                r_fetch_pc <= w_target;
                                r_addr     <= w_target;
                            end else begin
                                r_addr <= r_fetch_pc;
                            end
                        end else begin
                            r_state   <= HOLD;
                            r_valid   <= 1'b1;
                            r_meta.pc <= FETCH_ADDR_W'(r_fetch_pc);
                            r_inst    <= imem_rdata;
                        end
                    end else if (w_redirect) begin
                        r_fetch_pc <= w_target;
                        r_kill     <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_redirect || w_xfer) begin
                        r_state    <= REQ;
                        r_valid    <= 1'b0;
                        r_req      <= 1'b1;
                        r_fetch_pc <= w_hold_npc;
                        r_addr     <= w_hold_npc;
                        if (w_xfer) begin
                            r_meta.branch      <= w_pred_taken;
                            r_meta.branch_addr <= FETCH_ADDR_W'(w_pred_pc);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req        = r_req;
    assign imem_addr       = r_addr;
    assign out_valid       = r_valid;
    assign out_pc          = w_out_pc;
    assign out_inst        = r_inst;
    assign out_branch      = r_meta.branch;
    assign out_branch_addr = ADDR_WIDTH'(r_meta.branch_addr);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// against a PC-stream reference model. Works with or without FETCH_PRED_EN.
module tb_fetch_ctrl;

    localparam int unsigned      AW     = 32;
    localparam int unsigned      IW     = 32;
    localparam logic [AW-1:0]    RST_PC = 32'h1c00_0000;
    localparam logic [IW-1:0]    KINST  = 32'h0280_0000;
`ifdef FETCH_PRED_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          excp_flush = 1'b0, br_redirect = 1'b0, pred_taken = 1'b0;
    logic [AW-1:0] excp_pc = '0, br_pc = '0, pred_pc = '0;
    logic          imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          out_valid, out_ready = 1'b1, out_branch;
    logic [AW-1:0] out_pc, out_branch_addr;
    logic [IW-1:0] out_inst;

    int n_checks = 0;
    int n_pass   = 0;

    // instruction-memory model state
    bit            cfg_const, cfg_rand, m_hold_gnt, m_busy;
    int            cfg_gnt_lat, cfg_rsp_lat, m_gwait, m_lat;
    logic [AW-1:0] m_addr;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .excp_flush(excp_flush), .excp_pc(excp_pc),
        .br_redirect(br_redirect), .br_pc(br_pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_branch(out_branch), .out_branch_addr(out_branch_addr)
    );

    function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
        return cfg_const ? KINST : (a ^ 32'hA5A5_5A5A);
    endfunction

    function automatic int pick_gnt();
        return cfg_rand ? int'($urandom_range(3, 0)) : cfg_gnt_lat;
    endfunction

    function automatic int pick_rsp();
        return cfg_rand ? int'($urandom_range(3, 1)) : cfg_rsp_lat;
    endfunction

    function automatic logic [AW-1:0] pick_target();
        if ($urandom_range(7, 0) == 0) return 32'hFFFF_FFFF;
        return RST_PC | (AW'($urandom) & 32'h0000_FFFF);
    endfunction

    // Advance one cycle and let the memory model react to the new DUT outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (rst) begin
            m_busy  = 1'b0;
            m_gwait = pick_gnt();
        end else if (m_busy) begin
            m_lat--;
            if (m_lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data(m_addr);
                m_busy      = 1'b0;
            end
        end else if (imem_req && !m_hold_gnt) begin
            if (m_gwait == 0) begin
                imem_gnt = 1'b1;
                m_busy   = 1'b1;
                m_lat    = pick_rsp();
                m_addr   = imem_addr;
                m_gwait  = pick_gnt();
            end else begin
                m_gwait--;
            end
        end else if (!imem_req) begin
            m_gwait = pick_gnt();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; excp_flush = 1'b0; br_redirect = 1'b0; pred_taken = 1'b0;
        pred_pc = '0; out_ready = 1'b1; m_hold_gnt = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== RST_PC) $display("FAIL rst_addr: got %h expected %h", imem_addr, RST_PC); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if ({out_pc, out_inst} !== 64'h0) $display("FAIL rst_out: got %h/%h expected 0/0", out_pc, out_inst); else n_pass++;
        n_checks++; if ({out_branch, out_branch_addr} !== 33'h0) $display("FAIL rst_branch: got %b/%h expected 0/0", out_branch, out_branch_addr); else n_pass++;
        tick();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, RST_PC}) $display("FAIL first_req: got %b/%h expected 1/%h", imem_req, imem_addr, RST_PC); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [AW-1:0] exp_addr, exp_pc;
        int            last_hs, n_hs;
        bit            prev_req;
        cfg_const = 1'b1; cfg_rand = 1'b0; cfg_gnt_lat = 1; cfg_rsp_lat = 1;
        do_reset();
        exp_addr = RST_PC; exp_pc = RST_PC; last_hs = -1; n_hs = 0; prev_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (imem_req && !prev_req) begin
                n_checks++; if (imem_addr !== exp_addr) $display("FAIL seq_addr: got %h expected %h", imem_addr, exp_addr); else n_pass++;
                exp_addr += 4;
            end
            if (out_valid && out_ready) begin
                n_checks++; if ({out_pc, out_inst} !== {exp_pc, KINST}) $display("FAIL seq_out: got %h/%h expected %h/%h", out_pc, out_inst, exp_pc, KINST); else n_pass++;
                if (last_hs >= 0) begin
                    n_checks++; if (c - last_hs != 4) $display("FAIL seq_interval: got %0d expected 4", c - last_hs); else n_pass++;
                end
                last_hs = c; exp_pc += 4; n_hs++;
            end
            prev_req = imem_req;
            tick();
        end
        n_checks++; if (n_hs != 9) $display("FAIL seq_beats: got %0d expected 9", n_hs); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        int t;
        bit seen;
        cfg_const = 1'b0; cfg_rand = 1'b0; cfg_gnt_lat = 0; cfg_rsp_lat = 3;
        do_reset();
        t = 0;
        while (!imem_gnt && t < 20) begin tick(); t++; end
        n_checks++; if (imem_gnt !== 1'b1) $display("FAIL rw_gnt_timeout: got %b expected 1", imem_gnt); else n_pass++;
        tick();
        br_redirect = 1'b1; br_pc = 32'h1c00_0100;
        tick();
        br_redirect = 1'b0;
        t = 0; seen = 1'b0;
        while (!imem_req && t < 20) begin
            if (out_valid) seen = 1'b1;
            tick(); t++;
        end
        n_checks++; if (seen) $display("FAIL rw_dropped: got out_valid 1 expected 0"); else n_pass++;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h1c00_0100}) $display("FAIL rw_addr: got %b/%h expected 1/1c000100", imem_req, imem_addr); else n_pass++;
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        n_checks++; if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h1c00_0100, mem_data(32'h1c00_0100)}) $display("FAIL rw_out: got %b/%h/%h expected 1/1c000100/%h", out_valid, out_pc, out_inst, mem_data(32'h1c00_0100)); else n_pass++;
    endtask

    task automatic test_dual_redirect();
        int t;
        cfg_const = 1'b0; cfg_rand = 1'b0; cfg_gnt_lat = 0; cfg_rsp_lat = 1;
        do_reset();
        out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL dual_hold_timeout: got %b expected 1", out_valid); else n_pass++;
        excp_flush = 1'b1; excp_pc = 32'h1c00_8000; br_redirect = 1'b1; br_pc = 32'h1c00_0100;
        tick();
        excp_flush = 1'b0; br_redirect = 1'b0;
        n_checks++; if ({out_valid, imem_req, imem_addr} !== {2'b01, 32'h1c00_8000}) $display("FAIL dual_addr: got %b/%b/%h expected 0/1/1c008000", out_valid, imem_req, imem_addr); else n_pass++;
        out_ready = 1'b1;
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'h1c00_8000}) $display("FAIL dual_out: got %b/%h expected 1/1c008000", out_valid, out_pc); else n_pass++;
    endtask

    task automatic test_redirect_req();
        int            t;
        bit            seen, prev_req;
        logic [AW-1:0] a0;
        cfg_const = 1'b0; cfg_rand = 1'b0; cfg_gnt_lat = 0; cfg_rsp_lat = 1;
        do_reset();
        m_hold_gnt = 1'b1;
        t = 0;
        while (!imem_req && t < 20) begin tick(); t++; end
        a0 = imem_addr;
        br_redirect = 1'b1; br_pc = 32'h1c00_0300;
        tick();
        br_redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({imem_req, imem_addr} !== {1'b1, a0}) $display("FAIL rq_stable: got %b/%h expected 1/%h", imem_req, imem_addr, a0); else n_pass++;
            tick();
        end
        m_hold_gnt = 1'b0;
        t = 0; seen = 1'b0; prev_req = 1'b1;
        while (t < 20) begin
            tick(); t++;
            if (out_valid) seen = 1'b1;
            if (imem_req && !prev_req) break;
            prev_req = imem_req;
        end
        n_checks++; if (seen) $display("FAIL rq_dropped: got out_valid 1 expected 0"); else n_pass++;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h1c00_0300}) $display("FAIL rq_target: got %b/%h expected 1/1c000300", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_hold_stall();
        int            t;
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
        cfg_const = 1'b0; cfg_rand = 1'b0; cfg_gnt_lat = 0; cfg_rsp_lat = 1;
        do_reset();
        out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        pc = out_pc; inst = out_inst;
        n_checks++; if ({out_valid, pc} !== {1'b1, RST_PC}) $display("FAIL hs_first: got %b/%h expected 1/%h", out_valid, pc, RST_PC); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if ({out_valid, imem_req, out_pc, out_inst} !== {2'b10, pc, inst}) $display("FAIL hs_stable: got %b/%b/%h/%h expected 1/0/%h/%h", out_valid, imem_req, out_pc, out_inst, pc, inst); else n_pass++;
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if ({out_valid, imem_req, imem_addr} !== {2'b01, pc + 32'd4}) $display("FAIL hs_next: got %b/%b/%h expected 0/1/%h", out_valid, imem_req, imem_addr, pc + 32'd4); else n_pass++;
    endtask

    task automatic test_pred();
        int            t;
        logic [AW-1:0] exp_addr, exp_baddr;
        cfg_const = 1'b0; cfg_rand = 1'b0; cfg_gnt_lat = 1; cfg_rsp_lat = 1;
        do_reset();
        t = 0;
        while (!(out_valid && out_pc == 32'h1c00_0008) && t < 40) begin tick(); t++; end
        n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'h1c00_0008}) $display("FAIL pred_reach: got %b/%h expected 1/1c000008", out_valid, out_pc); else n_pass++;
        pred_taken = 1'b1; pred_pc = 32'h1c00_0200;
        tick();
        pred_taken = 1'b0; pred_pc = '0;
        exp_addr  = PRED_EN ? 32'h1c00_0200 : 32'h1c00_000c;
        exp_baddr = PRED_EN ? 32'h1c00_0200 : 32'h0;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, exp_addr}) $display("FAIL pred_addr: got %b/%h expected 1/%h", imem_req, imem_addr, exp_addr); else n_pass++;
        n_checks++; if ({out_branch, out_branch_addr} !== {PRED_EN, exp_baddr}) $display("FAIL pred_branch: got %b/%h expected %b/%h", out_branch, out_branch_addr, PRED_EN, exp_baddr); else n_pass++;
    endtask

    // Random traffic; the model tracks only the PC of the next instruction owed to decode.
    task automatic test_random();
        logic [AW-1:0] m_next, prev_addr, exp_baddr;
        bit            prev_req, prev_gnt, hs_prev, exp_br;
        int            n_hs;
        cfg_const = 1'b0; cfg_rand = 1'b1;
        do_reset();
        m_next = RST_PC; prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;
        hs_prev = 1'b0; exp_br = 1'b0; exp_baddr = '0; n_hs = 0;
        for (int c = 0; c < 3000; c++) begin
            if (imem_req && !prev_req) begin
                n_checks++; if (imem_addr !== m_next) $display("FAIL rnd_req_addr: got %h expected %h", imem_addr, m_next); else n_pass++;
            end
            if (prev_req && !prev_gnt) begin
                n_checks++; if ({imem_req, imem_addr} !== {1'b1, prev_addr}) $display("FAIL rnd_req_hold: got %b/%h expected 1/%h", imem_req, imem_addr, prev_addr); else n_pass++;
            end
            if (hs_prev) begin
                n_checks++; if ({out_branch, out_branch_addr} !== {exp_br, exp_baddr}) $display("FAIL rnd_branch: got %b/%h expected %b/%h", out_branch, out_branch_addr, exp_br, exp_baddr); else n_pass++;
            end
            excp_flush  = (c > 2) && ($urandom_range(15, 0) == 0);
            br_redirect = (c > 2) && ($urandom_range(9, 0) == 0);
            excp_pc     = pick_target();
            br_pc       = pick_target();
            pred_taken  = ($urandom_range(3, 0) == 0);
            pred_pc     = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : (RST_PC | (AW'($urandom) & 32'h0000_FFFC));
            out_ready   = ($urandom_range(3, 0) != 0);
            hs_prev = out_valid && out_ready;
            if (hs_prev) begin
                n_checks++; if ({out_pc, out_inst} !== {m_next, mem_data(m_next)}) $display("FAIL rnd_out: got %h/%h expected %h/%h", out_pc, out_inst, m_next, mem_data(m_next)); else n_pass++;
                exp_br    = PRED_EN && pred_taken;
                exp_baddr = PRED_EN ? pred_pc : '0;
                m_next    = exp_br ? pred_pc : out_pc + 32'd4;
                n_hs++;
            end
            if (excp_flush) m_next = excp_pc & ~32'd3;
            else if (br_redirect) m_next = br_pc & ~32'd3;
            prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
            tick();
        end
        excp_flush = 1'b0; br_redirect = 1'b0; pred_taken = 1'b0; out_ready = 1'b1;
        n_checks++; if (n_hs < 50) $display("FAIL rnd_progress: got %0d beats expected at least 50", n_hs); else n_pass++;
    endtask

    initial begin
        cfg_const = 1'b1; cfg_rand = 1'b0; cfg_gnt_lat = 1; cfg_rsp_lat = 1;
        m_hold_gnt = 1'b0; m_busy = 1'b0; m_gwait = 0; m_lat = 0; m_addr = '0;
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_dual_redirect();
        test_redirect_req();
        test_hold_stall();
        test_pred();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
